// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the cpu/dbg memory arbiter.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_RESP  = 2'd3
  } state_e;

  typedef enum logic {
    OWN_CPU = 1'b0,
    OWN_DBG = 1'b1
  } owner_e;

  localparam logic [1:0] SIZE_BYTE = 2'd0;
  localparam logic [1:0] SIZE_HALF = 2'd1;
  localparam logic [1:0] SIZE_WORD = 2'd2;

  localparam int LAT_MAX = 7;

endpackage

// File: rtl/mem_arb_pick.sv
// Winner selection for the two requesters; grant is one-hot, indexed by owner_e.
// MEM_ARB_RR_EN selects round-robin on ptr; otherwise dbg has fixed priority.
module mem_arb_pick
  import mem_arb_pkg::*;
(
  input  logic [1:0] reqs,
  input  logic       ptr,
  output logic [1:0] grant
);

`ifdef MEM_ARB_RR_EN
  // ptr = 0 prefers cpu, ptr = 1 prefers dbg.
  always_comb begin
    grant = 2'b00;
    if (reqs[OWN_CPU] && reqs[OWN_DBG]) begin
      grant[OWN_DBG] = ptr;
      grant[OWN_CPU] = ~ptr;
    end else begin
      grant = reqs;
    end
  end
`else
  logic unused_ptr;
  assign unused_ptr = ptr;

  always_comb begin
    grant = 2'b00;
    if (reqs[OWN_DBG])      grant[OWN_DBG] = 1'b1;
    else if (reqs[OWN_CPU]) grant[OWN_CPU] = 1'b1;
  end
`endif

endmodule

// File: rtl/mem_arb.sv
// Two-requester (cpu/dbg) memory arbiter, one transaction outstanding, fixed LAT response.
// Define MEM_ARB_RR_EN for round-robin arbitration; default build is fixed dbg priority.
module mem_arb
  import mem_arb_pkg::*;
#(
  parameter int LAT = 1,
  parameter int AW  = 32
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          cpu_req,
  input  logic          cpu_we,
  input  logic [AW-1:0] cpu_addr,
  input  logic [31:0]   cpu_wdata,
  input  logic [1:0]    cpu_size,
  output logic          cpu_gnt,
  output logic          cpu_done,
  output logic [31:0]   cpu_rdata,
  output logic          cpu_err,
  input  logic          dbg_req,
  input  logic          dbg_we,
  input  logic [AW-1:0] dbg_addr,
  input  logic [31:0]   dbg_wdata,
  input  logic [1:0]    dbg_size,
  output logic          dbg_gnt,
  output logic          dbg_done,
  output logic [31:0]   dbg_rdata,
  output logic          dbg_err,
  output logic          mem_rd,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [31:0]   mem_data,
  output logic [1:0]    mem_size,
  input  logic [31:0]   mem_out,
  input  logic          mem_error
);

  localparam int LAT_C = (LAT > LAT_MAX) ? LAT_MAX : ((LAT < 1) ? 1 : LAT);
  localparam logic [2:0] CNT_LOAD = 3'(LAT_C - 1);

  state_e        state_q, state_d;
  owner_e        owner_q, owner_d;
  logic          we_q, we_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [31:0]   wdata_q, wdata_d;
  logic [1:0]    size_q, size_d;
  logic [2:0]    cnt_q, cnt_d;
  logic [31:0]   cpu_rdata_q, cpu_rdata_d, dbg_rdata_q, dbg_rdata_d;
  logic          cpu_err_q, cpu_err_d, dbg_err_q, dbg_err_d;
  logic [1:0]    grant;
  logic          ptr;
  logic          idle, resp;

  mem_arb_pick u_pick (
    .reqs  ({dbg_req, cpu_req}),
    .ptr   (ptr),
    .grant (grant)
  );

`ifdef MEM_ARB_RR_EN
  logic ptr_q, ptr_d;
  assign ptr = ptr_q;

  // After serving cpu, prefer dbg next, and vice versa.
  always_comb begin
    ptr_d = ptr_q;
    if (state_q == S_IDLE && (|grant)) ptr_d = grant[OWN_CPU];
  end

  always_ff @(posedge clk) begin
    if (rst) ptr_q <= 1'b0;
    else     ptr_q <= ptr_d;
  end
`else
  assign ptr = 1'b0;
`endif

  always_comb begin
    state_d     = state_q;
    owner_d     = owner_q;
    we_d        = we_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    size_d      = size_q;
    cnt_d       = cnt_q;
    cpu_rdata_d = cpu_rdata_q;
    cpu_err_d   = cpu_err_q;
    dbg_rdata_d = dbg_rdata_q;
    dbg_err_d   = dbg_err_q;
    case (state_q)
      S_IDLE: begin
        if (|grant) begin
          owner_d = grant[OWN_DBG] ? OWN_DBG : OWN_CPU;
          we_d    = grant[OWN_DBG] ? dbg_we    : cpu_we;
          addr_d  = grant[OWN_DBG] ? dbg_addr  : cpu_addr;
          wdata_d = grant[OWN_DBG] ? dbg_wdata : cpu_wdata;
          size_d  = grant[OWN_DBG] ? dbg_size  : cpu_size;
          state_d = S_ISSUE;
        end
      end
      S_ISSUE: begin
        cnt_d   = CNT_LOAD;
        state_d = (LAT_C > 1) ? S_WAIT : S_RESP;
      end
      S_WAIT: begin
        cnt_d = (cnt_q != 3'd0) ? cnt_q - 3'd1 : 3'd0;
        if (cnt_q <= 3'd1) state_d = S_RESP;
      end
      S_RESP: begin
        if (owner_q == OWN_CPU) begin
          cpu_rdata_d = mem_out;
          cpu_err_d   = mem_error;
        end else begin
          dbg_rdata_d = mem_out;
          dbg_err_d   = mem_error;
        end
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      owner_q     <= OWN_CPU;
      we_q        <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      size_q      <= '0;
      cnt_q       <= '0;
      cpu_rdata_q <= '0;
      cpu_err_q   <= 1'b0;
      dbg_rdata_q <= '0;
      dbg_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      owner_q     <= owner_d;
      we_q        <= we_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      size_q      <= size_d;
      cnt_q       <= cnt_d;
      cpu_rdata_q <= cpu_rdata_d;
      cpu_err_q   <= cpu_err_d;
      dbg_rdata_q <= dbg_rdata_d;
      dbg_err_q   <= dbg_err_d;
    end
  end

  // Read data is visible during the done pulse itself, then held from the register.
  assign idle      = (state_q == S_IDLE) && !rst;
  assign resp      = (state_q == S_RESP);
  assign cpu_gnt   = idle && grant[OWN_CPU];
  assign dbg_gnt   = idle && grant[OWN_DBG];
  assign cpu_done  = resp && (owner_q == OWN_CPU);
  assign dbg_done  = resp && (owner_q == OWN_DBG);
  assign cpu_rdata = cpu_done ? mem_out   : cpu_rdata_q;
  assign cpu_err   = cpu_done ? mem_error : cpu_err_q;
  assign dbg_rdata = dbg_done ? mem_out   : dbg_rdata_q;
  assign dbg_err   = dbg_done ? mem_error : dbg_err_q;
  assign mem_rd    = (state_q == S_ISSUE) && !we_q;
  assign mem_we    = (state_q == S_ISSUE) && we_q;
  assign mem_addr  = addr_q;
  assign mem_data  = wdata_q;
  assign mem_size  = size_q;

endmodule

// File: tb/tb_mem_arb.sv
// Directed scoreboard bench for mem_arb: instance a uses LAT=1, instance b uses LAT=3.
module tb_mem_arb;
  localparam int AW = 32;

  typedef struct {
    logic        own;
    logic [31:0] rdata;
    logic        err;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  logic cpu_req, cpu_we, dbg_req, dbg_we, mem_error;
  logic [AW-1:0] cpu_addr, dbg_addr;
  logic [31:0] cpu_wdata, dbg_wdata, mem_out;
  logic [1:0] cpu_size, dbg_size;

  logic a_cpu_gnt, a_cpu_done, a_cpu_err, a_dbg_gnt, a_dbg_done, a_dbg_err, a_mem_rd, a_mem_we;
  logic [31:0] a_cpu_rdata, a_dbg_rdata, a_mem_data;
  logic [AW-1:0] a_mem_addr;
  logic [1:0] a_mem_size;
  logic b_cpu_gnt, b_cpu_done, b_cpu_err, b_dbg_gnt, b_dbg_done, b_dbg_err, b_mem_rd, b_mem_we;
  logic [31:0] b_cpu_rdata, b_dbg_rdata, b_mem_data;
  logic [AW-1:0] b_mem_addr;
  logic [1:0] b_mem_size;

  int n_cmp = 0;
  int n_bad = 0;
  exp_t sb[$];

  always #5 clk = ~clk;

  mem_arb #(.LAT(1), .AW(AW)) u_a (
    .clk(clk), .rst(rst),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata), .cpu_size(cpu_size),
    .cpu_gnt(a_cpu_gnt), .cpu_done(a_cpu_done), .cpu_rdata(a_cpu_rdata), .cpu_err(a_cpu_err),
    .dbg_req(dbg_req), .dbg_we(dbg_we), .dbg_addr(dbg_addr), .dbg_wdata(dbg_wdata), .dbg_size(dbg_size),
    .dbg_gnt(a_dbg_gnt), .dbg_done(a_dbg_done), .dbg_rdata(a_dbg_rdata), .dbg_err(a_dbg_err),
    .mem_rd(a_mem_rd), .mem_we(a_mem_we), .mem_addr(a_mem_addr), .mem_data(a_mem_data),
    .mem_size(a_mem_size), .mem_out(mem_out), .mem_error(mem_error)
  );

  mem_arb #(.LAT(3), .AW(AW)) u_b (
    .clk(clk), .rst(rst),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata), .cpu_size(cpu_size),
    .cpu_gnt(b_cpu_gnt), .cpu_done(b_cpu_done), .cpu_rdata(b_cpu_rdata), .cpu_err(b_cpu_err),
    .dbg_req(dbg_req), .dbg_we(dbg_we), .dbg_addr(dbg_addr), .dbg_wdata(dbg_wdata), .dbg_size(dbg_size),
    .dbg_gnt(b_dbg_gnt), .dbg_done(b_dbg_done), .dbg_rdata(b_dbg_rdata), .dbg_err(b_dbg_err),
    .mem_rd(b_mem_rd), .mem_we(b_mem_we), .mem_addr(b_mem_addr), .mem_data(b_mem_data),
    .mem_size(b_mem_size), .mem_out(mem_out), .mem_error(mem_error)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic nxt();
    @(posedge clk);
    #1;
  endtask

  task automatic mid();
    @(negedge clk);
  endtask

  task automatic do_reset();
    nxt();
    rst = 1'b1;
    cpu_req = 0; cpu_we = 0; cpu_addr = '0; cpu_wdata = '0; cpu_size = '0;
    dbg_req = 0; dbg_we = 0; dbg_addr = '0; dbg_wdata = '0; dbg_size = '0;
    mem_out = '0; mem_error = 0;
    nxt();
    nxt();
    rst = 1'b0;
  endtask

  // Called in the strobe cycle; steps until the chosen instance pulses done
  // and compares against the oldest scoreboard entry.
  task automatic wait_done(input bit use_b, input int exp_n, input string tag);
    bit seen;
    logic cd, dd, st;
    exp_t e;
    seen = 0;
    for (int n = 1; n <= 10 && !seen; n++) begin
      nxt();
      mid();
      cd = use_b ? b_cpu_done : a_cpu_done;
      dd = use_b ? b_dbg_done : a_dbg_done;
      st = use_b ? (b_mem_rd | b_mem_we) : (a_mem_rd | a_mem_we);
      if (cd | dd) begin
        seen = 1;
        chk({tag, "_lat"}, n, exp_n);
        chk({tag, "_sb_nonempty"}, (sb.size() > 0), 1);
        if (sb.size() > 0) begin
          e = sb.pop_front();
          chk({tag, "_owner"}, {dd, cd}, e.own ? 2'b10 : 2'b01);
          if (e.own) begin
            chk({tag, "_rdata"}, use_b ? b_dbg_rdata : a_dbg_rdata, e.rdata);
            chk({tag, "_err"}, use_b ? b_dbg_err : a_dbg_err, e.err);
          end else begin
            chk({tag, "_rdata"}, use_b ? b_cpu_rdata : a_cpu_rdata, e.rdata);
            chk({tag, "_err"}, use_b ? b_cpu_err : a_cpu_err, e.err);
          end
        end
      end else begin
        chk({tag, "_no_strobe"}, st, 0);
      end
    end
    chk({tag, "_done_seen"}, seen, 1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bit got;
    logic own;
    rst = 1'b1;
    do_reset();

    // Reset state
    mid();
    chk("rst_a_zero", |{a_cpu_gnt, a_dbg_gnt, a_cpu_done, a_dbg_done, a_cpu_rdata, a_dbg_rdata,
                        a_cpu_err, a_dbg_err, a_mem_rd, a_mem_we, a_mem_addr, a_mem_data, a_mem_size}, 0);
    chk("rst_b_zero", |{b_cpu_gnt, b_dbg_gnt, b_cpu_done, b_dbg_done, b_cpu_rdata, b_dbg_rdata,
                        b_cpu_err, b_dbg_err, b_mem_rd, b_mem_we, b_mem_addr, b_mem_data, b_mem_size}, 0);

    // cpu read, LAT=1
    do_reset();
    cpu_req = 1; cpu_we = 0; cpu_addr = 'h100; cpu_size = 2'd2;
    mem_out = 32'hDEADBEEF; mem_error = 0;
    mid();
    chk("rd_gnt", {a_cpu_gnt, a_dbg_gnt}, 2'b10);
    sb.push_back('{own: 1'b0, rdata: 32'hDEADBEEF, err: 1'b0});
    nxt();
    cpu_req = 0;
    mid();
    chk("rd_strobe", {a_mem_rd, a_mem_we}, 2'b10);
    chk("rd_addr", a_mem_addr, 'h100);
    chk("rd_size", a_mem_size, 2'd2);
    chk("rd_no_early_done", a_cpu_done, 0);
    wait_done(0, 1, "rd");
    nxt();
    mem_out = 32'h0;
    mid();
    chk("rd_hold_rdata", a_cpu_rdata, 32'hDEADBEEF);
    chk("rd_done_low", a_cpu_done, 0);
    chk("rd_addr_hold", a_mem_addr, 'h100);

    // Simultaneous requests, 4 transactions
    do_reset();
    cpu_req = 1; cpu_we = 0; cpu_addr = 'h10;
    dbg_req = 1; dbg_we = 0; dbg_addr = 'h20;
    for (int t = 0; t < 4; t++) begin
      if (t > 0) nxt();
      got = 0;
      for (int c = 0; c < 6 && !got; c++) begin
        if (c > 0) nxt();
        mid();
        if (a_cpu_gnt | a_dbg_gnt) got = 1;
      end
      chk("arb_gnt_seen", got, 1);
      chk("arb_gnt_onehot", a_cpu_gnt & a_dbg_gnt, 0);
      own = a_dbg_gnt;
`ifdef MEM_ARB_RR_EN
      chk("arb_rr_winner", own, (t % 2 == 1));
`else
      chk("arb_fixed_winner", own, 1'b1);
`endif
      mem_out = 32'h1000 + t;
      sb.push_back('{own: own, rdata: 32'h1000 + t, err: 1'b0});
      nxt();
      mid();
      chk("arb_strobe", {a_mem_rd, a_mem_we}, 2'b10);
      chk("arb_addr", a_mem_addr, own ? 'h20 : 'h10);
      wait_done(0, 1, "arb");
    end
    cpu_req = 0; dbg_req = 0;

    // dbg write with error, LAT=3
    do_reset();
    dbg_req = 1; dbg_we = 1; dbg_addr = 'h200; dbg_wdata = 32'h55; dbg_size = 2'd0;
    mem_out = 32'h12345678; mem_error = 1;
    mid();
    chk("wr_gnt", {b_cpu_gnt, b_dbg_gnt}, 2'b01);
    sb.push_back('{own: 1'b1, rdata: 32'h12345678, err: 1'b1});
    nxt();
    dbg_req = 0;
    mid();
    chk("wr_strobe", {b_mem_rd, b_mem_we}, 2'b01);
    chk("wr_addr", b_mem_addr, 'h200);
    chk("wr_data", b_mem_data, 32'h55);
    wait_done(1, 3, "wr");
    mem_error = 0;

    // Reset during WAIT, then a normal transaction
    do_reset();
    cpu_req = 1; cpu_we = 0; cpu_addr = 'h300;
    mid();
    chk("rstw_gnt", b_cpu_gnt, 1);
    nxt();
    cpu_req = 0;
    nxt();
    rst = 1;
    mid();
    chk("rstw_in_wait", {b_mem_rd, b_mem_we, b_cpu_done}, 0);
    nxt();
    rst = 0;
    mid();
    chk("rstw_b_zero", |{b_cpu_gnt, b_dbg_gnt, b_cpu_done, b_dbg_done, b_cpu_rdata, b_dbg_rdata,
                         b_cpu_err, b_dbg_err, b_mem_rd, b_mem_we, b_mem_addr, b_mem_data, b_mem_size}, 0);
    chk("rstw_a_zero", |{a_cpu_gnt, a_dbg_gnt, a_cpu_done, a_dbg_done, a_cpu_rdata, a_dbg_rdata,
                         a_cpu_err, a_dbg_err, a_mem_rd, a_mem_we, a_mem_addr, a_mem_data, a_mem_size}, 0);
    nxt();
    mid();
    chk("rstw_no_done", b_cpu_done | b_dbg_done, 0);
    nxt();
    cpu_req = 1; cpu_addr = 'h304; mem_out = 32'hA5A5A5A5;
    mid();
    chk("rstw_next_gnt", b_cpu_gnt, 1);
    sb.push_back('{own: 1'b0, rdata: 32'hA5A5A5A5, err: 1'b0});
    nxt();
    cpu_req = 0;
    mid();
    chk("rstw_next_strobe", {b_mem_rd, b_mem_we}, 2'b10);
    chk("rstw_next_addr", b_mem_addr, 'h304);
    wait_done(1, 3, "rstw_next");

    // cpu req dropped after gnt, dbg pending
    do_reset();
    cpu_req = 1; cpu_we = 0; cpu_addr = 'h400; mem_out = 32'h0BADF00D;
    mid();
    chk("drop_gnt", a_cpu_gnt, 1);
    sb.push_back('{own: 1'b0, rdata: 32'h0BADF00D, err: 1'b0});
    nxt();
    cpu_req = 0; dbg_req = 1; dbg_we = 0; dbg_addr = 'h500;
    mid();
    chk("drop_pend_no_gnt", a_dbg_gnt, 0);
    chk("drop_strobe", a_mem_rd, 1);
    wait_done(0, 1, "drop");
    chk("drop_pend_no_gnt_resp", a_dbg_gnt, 0);
    nxt();
    mem_out = 32'h600D600D;
    mid();
    chk("pend_gnt", a_dbg_gnt, 1);
    sb.push_back('{own: 1'b1, rdata: 32'h600D600D, err: 1'b0});
    nxt();
    dbg_req = 0;
    mid();
    chk("pend_strobe", a_mem_rd, 1);
    chk("pend_addr", a_mem_addr, 'h500);
    wait_done(0, 1, "pend");
    chk("pend_cpu_rdata_kept", a_cpu_rdata, 32'h0BADF00D);
    chk("sb_drained", sb.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/mem_arb.md
MEM_ARB -- requirements
Module: mem_arb

Interface
REQ-001 SHALL have parameter LAT, default 1: memory read/write response latency in cycles after strobe (1..7).
REQ-002 SHALL have parameter AW, default 32: address width.
REQ-003 SHALL have ports `clk`  in  1  clock; `rst`  in  1  reset, synchronous, active-high.
REQ-004 SHALL have per-requester ports, x in {cpu, dbg}: `x_req` in 1 request; `x_we` in 1 write; `x_addr` in AW address; `x_wdata` in 32 write data; `x_size` in 2 access size.
REQ-005 SHALL have per-requester outputs: `x_gnt` out 1 transaction accepted; `x_done` out 1 response pulse; `x_rdata` out 32 read data; `x_err` out 1 memory error.
REQ-006 SHALL have memory-side ports: `mem_rd` out 1; `mem_we` out 1; `mem_addr` out AW; `mem_data` out 32; `mem_size` out 2; `mem_out` in 32; `mem_error` in 1.

Function
REQ-007 SHALL implement FSM states IDLE, ISSUE, WAIT, RESP.
REQ-008 IDLE: if any req, SHALL latch winner, we, addr, wdata and size, pulse winner's `x_gnt` for that cycle, and go to ISSUE; otherwise SHALL stay in IDLE.
REQ-009 ISSUE SHALL drive latched fields to memory, assert exactly one of `mem_rd`/`mem_we` for exactly one cycle, load the latency counter with LAT-1, and go to WAIT if LAT>1, else RESP.
REQ-010 WAIT SHALL decrement the counter each cycle and go to RESP when it reaches 0.
REQ-011 RESP SHALL pulse the owner's `x_done` for one cycle, with `x_rdata`=`mem_out` and `x_err`=`mem_error` registered that cycle, then return to IDLE.
REQ-012 Latency, LAT=1: req high at cycle k gives gnt at k, mem strobe at k+1 and done at k+2; generally done at k+1+LAT.
REQ-013 Only one transaction SHALL be outstanding; a new request SHALL be accepted no earlier than the IDLE cycle after RESP.
REQ-014 A req deasserted after gnt SHALL NOT abort the transaction; done SHALL still pulse.
REQ-015 A non-owner's req SHALL be held pending, with no gnt, until IDLE.
REQ-016 Outside ISSUE, `mem_rd`/`mem_we` SHALL be 0; `mem_addr`/`mem_data`/`mem_size` SHALL hold the latched values.
REQ-017 `x_rdata`/`x_err` SHALL hold their value between done pulses; the non-owner's SHALL be unchanged.
REQ-018 The latency counter SHALL be 3 bits wide and SHALL NOT wrap below 0.

Reset
REQ-019 With `rst`=1 at a clock edge, the FSM SHALL go to IDLE and every output, counter and latch SHALL be 0, including a round-robin pointer of 0 (cpu preferred next).
REQ-020 Reset mid-transaction SHALL drop the transaction with no done pulse; memory strobes SHALL be 0 from the cycle after the reset edge.

Configuration
REQ-021 Macro MEM_ARB_RR_EN defined: round-robin. On simultaneous reqs the requester not granted last SHALL win; the pointer SHALL update at each gnt.
REQ-022 MEM_ARB_RR_EN undefined: fixed priority. dbg SHALL always win simultaneous reqs; the pointer logic SHALL be absent.

Structure
REQ-023 Package mem_arb_pkg SHALL hold the FSM state enum, the owner enum (OWN_CPU, OWN_DBG), the size encodings (byte=0, half=1, word=2) and LAT_MAX=7.
REQ-024 Winner selection SHALL be a sub-module mem_arb_pick, with inputs reqs and pointer and a one-hot output grant.

Verification
REQ-025 cpu read addr 0x100, LAT=1, mem_out=0xDEADBEEF -> mem_rd at k+1, cpu_done at k+2, cpu_rdata=0xDEADBEEF, cpu_err=0.
REQ-026 Simultaneous cpu and dbg reqs, repeated 4 transactions -> RR_EN: grants alternate cpu,dbg,cpu,dbg; fixed priority: dbg 4 times, cpu starved while dbg_req is held.
REQ-027 LAT=3, dbg write 0x55 to 0x200, mem_error=1 -> mem_we one cycle, dbg_done at k+4, dbg_err=1.
REQ-028 `rst` pulsed during WAIT -> no done, FSM returns to IDLE, all outputs 0, next req completes normally.
REQ-029 cpu_req dropped the cycle after gnt -> cpu_done still pulses at k+2; a pending dbg req is granted in the following IDLE cycle.
